// File: rtl/ccff_pkg.sv
// Shared types and default sizing for the ccff chain loader.
package ccff_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_ld_state_t;

  // Default geometry: flops in the target chain and host word width.
  localparam int CCFF_CHAIN_LEN_DEF = 6;
  localparam int CCFF_DATA_W_DEF    = 8;

endpackage

// File: rtl/ccff_loader_if.sv
// Host/chain signal bundle for ccff_loader.
//
// Handshake: the host holds cfg_data stable while cfg_valid is high; a word
// is transferred on every prog_clk rising edge where cfg_valid and cfg_ready
// are both high. cfg_ready depends only on loader state, never on cfg_valid.
// Readback (rb_data/rb_valid) is a one-cycle pulse with no backpressure.
interface ccff_loader_if #(
  parameter int DATA_W = ccff_pkg::CCFF_DATA_W_DEF
);
  logic              start;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;

  // Host / chain side: drives requests, words and the returned tail bit.
  modport master (
    output start, cfg_data, cfg_valid, ccff_tail,
    input  cfg_ready, ccff_head, ccff_shift_en, busy, done, rb_data, rb_valid
  );

  // Loader side.
  modport slave (
    input  start, cfg_data, cfg_valid, ccff_tail,
    output cfg_ready, ccff_head, ccff_shift_en, busy, done, rb_data, rb_valid
  );
endinterface

// File: rtl/ccff_piso.sv
// Word register for the loader: parallel load of a host word, then a
// right shift per cycle so bit 0 always holds the next bit for the chain.
module ccff_piso #(
  parameter int DATA_W = ccff_pkg::CCFF_DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_bit
);

  logic [DATA_W-1:0] r_word;

  // Load has priority over shift; the two never coincide in the loader.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_data;
    end else if (i_shift) begin
      r_word <= r_word >> 1;
    end
  end

  assign o_bit = r_word[0];

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: streams host configuration words LSB-first into a serial
// configuration flip-flop chain of CHAIN_LEN flops, fetching exactly
// ceil(CHAIN_LEN/DATA_W) words per load.
// Optional feature macro: CCFF_READBACK_EN -- captures the bits falling
// out of the chain tail and presents them as DATA_W-bit readback words.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter int DATA_W    = CCFF_DATA_W_DEF
) (
  input  logic           prog_clk,
  input  logic           prog_reset_n,
  ccff_loader_if.slave   bus,
  output ccff_ld_state_t o_state
);

  localparam int TOT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(CHAIN_LEN);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  ccff_ld_state_t   r_state;
  ccff_ld_state_t   w_next;
  logic [TOT_W-1:0] r_tot_cnt;
  logic [TOT_W-1:0] w_tot_inc;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_inc;
  logic             w_hs;
  logic             w_shift;
  logic             w_last_bit;
  logic             w_word_end;
  logic             w_piso_bit;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;

  assign w_tot_inc  = r_tot_cnt + TOT_W'(1);
  assign w_bit_inc  = r_bit_cnt + BIT_W'(1);
  assign w_last_bit = (w_tot_inc == TOT_LAST);
  assign w_word_end = (w_bit_inc == BIT_LAST);
  assign w_hs       = w_ready && bus.cfg_valid;

  // State register.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs; chain end wins over word end.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_shift = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_ready = 1'b1;
        if (bus.cfg_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (w_last_bit)      w_next = ST_DONE;
        else if (w_word_end) w_next = ST_FETCH;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Total bit counter: cleared when a load starts, one step per shift.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_tot_cnt <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_tot_cnt <= '0;
    end else if (w_shift) begin
      r_tot_cnt <= w_tot_inc;
    end
  end

  // Word bit counter: cleared on each accepted word, one step per shift.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_bit_cnt <= '0;
    end else if (w_hs) begin
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_bit_cnt <= w_bit_inc;
    end
  end

  ccff_piso #(.DATA_W(DATA_W)) u_piso (
    .i_clk   (prog_clk),
    .i_rst_n (prog_reset_n),
    .i_load  (w_hs),
    .i_data  (bus.cfg_data),
    .i_shift (w_shift),
    .o_bit   (w_piso_bit)
  );

  assign bus.cfg_ready     = w_ready;
  assign bus.ccff_shift_en = w_shift;
  assign bus.ccff_head     = w_shift & w_piso_bit;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign o_state           = r_state;

`ifdef CCFF_READBACK_EN
  logic [DATA_W-1:0] r_rb_acc;
  logic [DATA_W-1:0] r_rb_data;
  logic              r_rb_valid;
  logic [DATA_W-1:0] w_rb_word;

  // The tail sample of this cycle lands at the same position the head bit
  // occupies in its word, so readback words align with host words.
  assign w_rb_word = r_rb_acc | (DATA_W'(bus.ccff_tail) << r_bit_cnt);

  // Collect tail samples; publish on a full word or on the final chain bit.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_rb_acc   <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_shift) begin
        if (w_last_bit || w_word_end) begin
          r_rb_data  <= w_rb_word;
          r_rb_valid <= 1'b1;
          r_rb_acc   <= '0;
        end else begin
          r_rb_acc <= w_rb_word;
        end
      end
    end
  end

  assign bus.rb_data  = r_rb_data;
  assign bus.rb_valid = r_rb_valid;
`else
  assign bus.rb_data  = '0;
  assign bus.rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a 6-flop/8-bit loader and a 12-flop/8-bit loader,
// each driving a behavioural chain model, checked every cycle against a
// word-level model of the expected head stream and readback words.
module tb_ccff_loader;
  import ccff_pkg::*;

  localparam int DW    = 8;
  localparam int LEN_A = 6;
  localparam int LEN_B = 12;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ccff_loader_if #(.DATA_W(DW)) if_a ();
  ccff_loader_if #(.DATA_W(DW)) if_b ();
  ccff_ld_state_t st_a;
  ccff_ld_state_t st_b;

  ccff_loader #(.CHAIN_LEN(LEN_A), .DATA_W(DW)) u_dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .bus(if_a), .o_state(st_a));
  ccff_loader #(.CHAIN_LEN(LEN_B), .DATA_W(DW)) u_dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .bus(if_b), .o_state(st_b));

  // Chain models (index 0 next to the head, top index is the tail)
  logic [LEN_A-1:0] chain_a = '0;
  logic [LEN_B-1:0] chain_b = '0;
  logic             pre_req_a, pre_req_b;
  logic [LEN_A-1:0] pre_val_a;
  logic [LEN_B-1:0] pre_val_b;

  always @(posedge clk) begin
    if (pre_req_a)               chain_a <= pre_val_a;
    else if (if_a.ccff_shift_en) chain_a <= {chain_a[LEN_A-2:0], if_a.ccff_head};
    if (pre_req_b)               chain_b <= pre_val_b;
    else if (if_b.ccff_shift_en) chain_b <= {chain_b[LEN_B-2:0], if_b.ccff_head};
  end
  assign if_a.ccff_tail = chain_a[LEN_A-1];
  assign if_b.ccff_tail = chain_b[LEN_B-1];

  // Scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic          hq_a[$];
  logic          hq_b[$];
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];

  int          shift_cnt[2];
  int          hs_cnt[2];
  int          pushed[2];
  int          ready_cyc[2];
  int          gap_cnt[2];
  int          done_total[2];
  int          last_shift_cyc[2];
  int          rb_n[2];
  int          rbv_cnt[2];
  logic [DW-1:0] rb_bits[2];
  logic [DW-1:0] rb_last[2];
  logic [15:0]   head_trace[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void clear_model(input int id);
    shift_cnt[id] = 0; hs_cnt[id] = 0; pushed[id] = 0; ready_cyc[id] = 0;
    gap_cnt[id] = 0; rb_n[id] = 0; rbv_cnt[id] = 0; rb_bits[id] = '0;
    head_trace[id] = '0; last_shift_cyc[id] = -10;
    if (id == 0) begin hq_a.delete(); exp_q_a.delete(); end
    else         begin hq_b.delete(); exp_q_b.delete(); end
  endfunction

  function automatic void push_head(input int id, input logic b);
    if (id == 0) hq_a.push_back(b); else hq_b.push_back(b);
  endfunction

  function automatic int head_left(input int id);
    return (id == 0) ? hq_a.size() : hq_b.size();
  endfunction

  function automatic logic pop_head(input int id);
    return (id == 0) ? hq_a.pop_front() : hq_b.pop_front();
  endfunction

  function automatic void push_word(input int id, input logic [DW-1:0] w);
    if (id == 0) exp_q_a.push_back(w); else exp_q_b.push_back(w);
  endfunction

  function automatic int words_left(input int id);
    return (id == 0) ? exp_q_a.size() : exp_q_b.size();
  endfunction

  function automatic logic [DW-1:0] pop_word(input int id);
    return (id == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
  endfunction

  // Per-cycle model update and comparison for one loader
  task automatic check_dut(input int id, input int clen, input logic stt,
                           input logic rdy, input logic vld, input logic [DW-1:0] dat,
                           input logic hd, input logic sh, input logic tl,
                           input logic bsy, input logic dn,
                           input logic [DW-1:0] rbd, input logic rbv);
    int n;
    logic b;
    logic [DW-1:0] w;
    if (!rst_n) begin
      clear_model(id);
      return;
    end
    if (!sh) check($sformatf("head_quiet[%0d]", id), {31'd0, hd}, 32'd0);
    check($sformatf("ready_and_shift[%0d]", id), {31'd0, rdy & sh}, 32'd0);
    if (rdy || sh || dn) check($sformatf("busy_active[%0d]", id), {31'd0, bsy}, 32'd1);
    if (stt && !bsy) clear_model(id);
    if (rdy) ready_cyc[id]++;
    if (bsy && !sh && !dn && shift_cnt[id] > 0) gap_cnt[id]++;
    if (sh) begin
      if (head_left(id) == 0) begin
        check($sformatf("head_underflow[%0d]", id), 32'd1, 32'd0);
      end else begin
        b = pop_head(id);
        check($sformatf("head_bit[%0d]", id), {31'd0, hd}, {31'd0, b});
      end
      if (shift_cnt[id] < 16) head_trace[id][shift_cnt[id]] = hd;
      shift_cnt[id]++;
      last_shift_cyc[id] = cyc;
      rb_bits[id][rb_n[id]] = tl;
      rb_n[id]++;
      if (rb_n[id] == DW || shift_cnt[id] == clen) begin
        push_word(id, rb_bits[id]);
        rb_bits[id] = '0;
        rb_n[id] = 0;
      end
    end
    if (rdy && vld) begin
      hs_cnt[id]++;
      n = clen - pushed[id];
      if (n > DW) n = DW;
      for (int k = 0; k < n; k++) push_head(id, dat[k]);
      pushed[id] += n;
    end
`ifdef CCFF_READBACK_EN
    if (rbv) begin
      rbv_cnt[id]++;
      rb_last[id] = rbd;
      if (words_left(id) == 0) begin
        check($sformatf("rb_unexpected[%0d]", id), 32'd1, 32'd0);
      end else begin
        w = pop_word(id);
        check($sformatf("rb_data[%0d]", id), {24'd0, rbd}, {24'd0, w});
      end
    end
`else
    if (rbv) rbv_cnt[id]++;
    check($sformatf("rb_off[%0d]", id), {23'd0, rbv, rbd}, 32'd0);
`endif
    if (dn) begin
      done_total[id]++;
      check($sformatf("done_shifts[%0d]", id), shift_cnt[id], clen);
      check($sformatf("done_bits_left[%0d]", id), head_left(id), 0);
      check($sformatf("done_latency[%0d]", id), cyc - last_shift_cyc[id], 1);
      check($sformatf("done_words[%0d]", id), hs_cnt[id], (clen + DW - 1) / DW);
`ifdef CCFF_READBACK_EN
      check($sformatf("done_rb_left[%0d]", id), words_left(id), 0);
`endif
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    cyc++;
    check_dut(0, LEN_A, if_a.start, if_a.cfg_ready, if_a.cfg_valid, if_a.cfg_data,
              if_a.ccff_head, if_a.ccff_shift_en, if_a.ccff_tail, if_a.busy, if_a.done,
              if_a.rb_data, if_a.rb_valid);
    check_dut(1, LEN_B, if_b.start, if_b.cfg_ready, if_b.cfg_valid, if_b.cfg_data,
              if_b.ccff_head, if_b.ccff_shift_en, if_b.ccff_tail, if_b.busy, if_b.done,
              if_b.rb_data, if_b.rb_valid);
  end

  // Driver tasks
  task automatic set_start(input int id, input logic v);
    if (id == 0) if_a.start = v; else if_b.start = v;
  endtask

  task automatic set_valid(input int id, input logic v, input logic [DW-1:0] d);
    if (id == 0) begin if_a.cfg_valid = v; if_a.cfg_data = d; end
    else         begin if_b.cfg_valid = v; if_b.cfg_data = d; end
  endtask

  function automatic logic get_ready(input int id);
    return (id == 0) ? if_a.cfg_ready : if_b.cfg_ready;
  endfunction

  function automatic logic get_done(input int id);
    return (id == 0) ? if_a.done : if_b.done;
  endfunction

  task automatic run_load(input int id, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input int nw, input int dly);
    logic ok;
    @(posedge clk); #1 set_start(id, 1'b1);
    @(posedge clk); #1 set_start(id, 1'b0);
    for (int w = 0; w < nw; w++) begin
      if (dly > 0) begin
        repeat (dly) @(posedge clk);
        #1;
      end
      set_valid(id, 1'b1, (w == 0) ? w0 : w1);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (get_ready(id)) begin ok = 1'b1; break; end
      end
      check("handshake_wait", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
    end
    set_valid(id, 1'b0, '0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (get_done(id)) begin ok = 1'b1; break; end
    end
    check("done_wait", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_outs"}, {if_a.cfg_ready, if_a.ccff_head, if_a.ccff_shift_en,
                             if_a.busy, if_a.done, if_a.rb_valid, if_a.rb_data}, 32'd0);
    check({tag, "_b_outs"}, {if_b.cfg_ready, if_b.ccff_head, if_b.ccff_shift_en,
                             if_b.busy, if_b.done, if_b.rb_valid, if_b.rb_data}, 32'd0);
    check({tag, "_a_state"}, {30'd0, st_a}, {30'd0, ST_IDLE});
    check({tag, "_b_state"}, {30'd0, st_b}, {30'd0, ST_IDLE});
  endtask

  // Stimulus
  int mark;
  int nsh;

  initial begin
    if_a.start = 1'b0; if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
    if_b.start = 1'b0; if_b.cfg_valid = 1'b0; if_b.cfg_data = '0;
    pre_req_a = 1'b1; pre_val_a = '0;
    pre_req_b = 1'b1; pre_val_b = '0;
    for (int i = 0; i < 2; i++) begin
      clear_model(i);
      done_total[i] = 0;
      rb_last[i] = '0;
    end

    // Reset state, before and after clock edges
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset_async");
    @(posedge clk); #1 pre_req_a = 1'b0; pre_req_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_clocked");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single word 0xA5 into a 6-flop chain
    mark = done_total[0];
    run_load(0, 8'hA5, 8'h00, 1, 0);
    check("a5_head_seq", {16'd0, 10'd0, head_trace[0][5:0]}, 32'h25);
    check("a5_shifts", shift_cnt[0], 6);
    check("a5_words", hs_cnt[0], 1);
    check("a5_dones", done_total[0] - mark, 1);
    check("a5_gaps", gap_cnt[0], 0);

    // Two words into a 12-flop chain
    mark = done_total[1];
    run_load(1, 8'h3C, 8'h0F, 2, 0);
    check("w2_head_seq", {20'd0, head_trace[1][11:0]}, 32'hF3C);
    check("w2_shifts", shift_cnt[1], 12);
    check("w2_words", hs_cnt[1], 2);
    check("w2_fetch_gap", gap_cnt[1], 1);
    check("w2_dones", done_total[1] - mark, 1);

    // Host word delayed three cycles in FETCH
    run_load(0, 8'h96, 8'h00, 1, 3);
    check("dly_ready_cycles", ready_cyc[0], 4);
    check("dly_head_seq", {16'd0, 10'd0, head_trace[0][5:0]}, 32'h16);
    check("dly_shifts", shift_cnt[0], 6);

    // start pulses while busy are ignored
    mark = done_total[0];
    fork
      run_load(0, 8'h3C, 8'h00, 1, 0);
      begin
        repeat (3) @(posedge clk);
        #1 if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 if_a.start = 1'b1;
        @(posedge clk); #1 if_a.start = 1'b0;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("busy_start_dones", done_total[0] - mark, 1);
    check("busy_start_idle", {31'd0, if_a.busy}, 32'd0);
    check("busy_start_state", {30'd0, st_a}, {30'd0, ST_IDLE});

    // Readback of preloaded chain contents
    @(posedge clk); #1;
    pre_val_a = 6'b110011; pre_req_a = 1'b1;
    pre_val_b = 12'hC35;   pre_req_b = 1'b1;
    @(posedge clk); #1 pre_req_a = 1'b0; pre_req_b = 1'b0;
    run_load(0, 8'h00, 8'h00, 1, 0);
    run_load(1, 8'hFF, 8'hFF, 2, 0);
`ifdef CCFF_READBACK_EN
    check("rb_a_pulses", rbv_cnt[0], 1);
    check("rb_a_word", {24'd0, rb_last[0]}, 32'h33);
    check("rb_b_pulses", rbv_cnt[1], 2);
    check("rb_b_last_word", {24'd0, rb_last[1]}, 32'h0A);
`else
    check("rb_a_pulses", rbv_cnt[0], 0);
    check("rb_b_pulses", rbv_cnt[1], 0);
`endif

    // Reset on the third SHIFT cycle
    mark = done_total[0];
    @(posedge clk); #1 if_a.start = 1'b1;
    @(posedge clk); #1 if_a.start = 1'b0;
    if_a.cfg_data = 8'hFF; if_a.cfg_valid = 1'b1;
    nsh = 0;
    for (int k = 0; k < 50 && nsh < 3; k++) begin
      @(negedge clk);
      if (if_a.ccff_shift_en) nsh++;
    end
    check("rst_reached_shift3", nsh, 3);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_midload");
    if_a.cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_after_state", {30'd0, st_a}, {30'd0, ST_IDLE});
    check("rst_after_busy", {31'd0, if_a.busy}, 32'd0);
    check("rst_no_done", done_total[0] - mark, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    n_errors++;
    $display("FAIL sim_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 CHAIN_LEN, default 6, number of configuration flip-flops in the target ccff chain (minimum 1).
REQ-002 DATA_W, default 8, bit width of one host configuration word (minimum 1).
REQ-003 prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-004 prog_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin one full chain load.
REQ-006 cfg_data  input  DATA_W  host configuration word; bit 0 is shifted first.
REQ-007 cfg_valid  input  1  host asserts when cfg_data holds a valid word.
REQ-008 cfg_ready  output  1  loader accepts a word on a cycle where cfg_valid and cfg_ready are both high.
REQ-009 ccff_head  output  1  serial bit driven into the chain head.
REQ-010 ccff_shift_en  output  1  chain advances one position on each prog_clk edge where this is high.
REQ-011 ccff_tail  input  1  serial bit returned from the chain tail.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a load completes.
REQ-014 rb_data  output  DATA_W  readback word of captured tail bits.
REQ-015 rb_valid  output  1  one-cycle pulse that qualifies rb_data.

Function
REQ-016 The FSM SHALL use the states IDLE, FETCH, SHIFT and DONE.
REQ-017 IDLE: start=1 moves to FETCH on the next cycle; start SHALL be ignored in every other state.
REQ-018 FETCH: cfg_ready=1; a handshake loads cfg_data into the word register, clears the word bit counter and moves to SHIFT; with no handshake the FSM stays in FETCH indefinitely.
REQ-019 SHIFT: ccff_shift_en=1 and ccff_head=word_reg[0] every cycle; the word register shifts right by one per cycle and the total bit counter increments by one per cycle.
REQ-020 SHIFT exit 1: when the total bit count reaches CHAIN_LEN, the FSM SHALL go to DONE, and remaining bits of the current word are discarded.
REQ-021 SHIFT exit 2: otherwise, when DATA_W bits of the current word have been shifted, the FSM SHALL go to FETCH.
REQ-022 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; the loader consumes exactly ceil(CHAIN_LEN/DATA_W) words.
REQ-023 Outside SHIFT, ccff_shift_en=0, ccff_head=0 and the chain SHALL never move.
REQ-024 Counters SHALL be sized to $clog2(CHAIN_LEN+1) bits (total) and $clog2(DATA_W+1) bits (word), with no wrap inside a load.
REQ-025 cfg_ready SHALL be combinational from state only, with no dependence on cfg_valid.

Reset
REQ-026 While prog_reset_n=0: state=IDLE, counters=0, word and readback registers=0, and cfg_ready, ccff_head, ccff_shift_en, busy, done, rb_valid, rb_data all =0.
REQ-027 Reset asserted mid-load aborts the load immediately, with no done pulse; chain contents are undefined and a new start is required.

Configuration
REQ-028 Macro CCFF_READBACK_EN defined: each SHIFT cycle samples ccff_tail into the readback register in LSB-first order.
REQ-029 With CCFF_READBACK_EN defined, a word SHALL be presented with a one-cycle rb_valid pulse after every DATA_W samples, and after the final sample when a partial word remains (upper bits zero). There is no backpressure on readback.
REQ-030 Macro CCFF_READBACK_EN undefined: rb_data=0 and rb_valid=0 constantly, the readback register is removed, and the ports remain present.

Structure
REQ-031 Shared package ccff_pkg SHALL hold the state enum type (ccff_ld_state_t) and the default CHAIN_LEN and DATA_W constants.
REQ-032 One sub-module, ccff_piso, SHALL implement the word register with parallel load and serial shift; the FSM and counters stay in ccff_loader.

Verification
REQ-033 Scenario: CHAIN_LEN=6, DATA_W=8; start, then cfg_data=0xA5 with valid held -> 6 shift_en cycles with head sequence 1,0,1,0,0,1, done one cycle after the last shift, exactly one word accepted.
REQ-034 Scenario: CHAIN_LEN=12; words 0x3C then 0x0F with valid held -> 8 shifts, 1 FETCH cycle with shift_en=0, 4 shifts, then done; 2 handshakes total.
REQ-035 Scenario: cfg_valid delayed 3 cycles in FETCH -> cfg_ready held high, shift_en=0 and head=0 throughout the wait, no bits lost.
REQ-036 Scenario: start pulsed while busy -> no effect; only one done per load.
REQ-037 Scenario: prog_reset_n low on the 3rd SHIFT cycle -> all outputs 0 in the same cycle, IDLE after release, no done pulse.
REQ-038 Scenario: CCFF_READBACK_EN defined, 6-flop chain model preloaded with tail-first bits 1,1,0,0,1,1 -> one rb_valid pulse with rb_data=0x33; without the macro -> rb_valid never asserts.
